// File: rtl/y_derivative_stream_if.sv
// y_derivative_stream_if: pixel-in / derivative-out stream bundle for y_derivative_stream
// Ports: in_valid, in_sof, pixels_in (producer -> block); out_valid, derivs_out, out_border, out_sat (block -> consumer)
// slave is the block's view, master is the producer/consumer view.
interface y_derivative_stream_if #(
  parameter int PIXEL_WIDTH = 8,
  parameter int NUM_FRAMES  = 3,
  parameter int OUT_WIDTH   = 9
);
  logic                              in_valid;
  logic                              in_sof;
  logic [PIXEL_WIDTH*NUM_FRAMES-1:0] pixels_in;
  logic                              out_valid;
  logic [OUT_WIDTH*NUM_FRAMES-1:0]   derivs_out;
  logic                              out_border;
  logic [NUM_FRAMES-1:0]             out_sat;
  modport slave (
    input  in_valid, in_sof, pixels_in,
    output out_valid, derivs_out, out_border, out_sat
  );
  modport master (
    output in_valid, in_sof, pixels_in,
    input  out_valid, derivs_out, out_border, out_sat
  );
endinterface

// File: rtl/y_derivative_stream.sv
// y_derivative_stream: vertical FIR derivative over a raster pixel stream, NUM_FRAMES channels in lockstep
// Ports: clk, rst (sync, active-high); bus (slave): in_valid/in_sof/pixels_in in,
//        out_valid/derivs_out/out_border/out_sat out, fixed 3-cycle latency, no backpressure.
module y_derivative_stream #(
  parameter int PIXEL_WIDTH   = 8,
  parameter int FRAME_WIDTH   = 1024,
  parameter int FRAME_HEIGHT  = 768,
  parameter int NUM_FRAMES    = 3,
  parameter int KERNEL_HEIGHT = 5,
  parameter int KERNEL [KERNEL_HEIGHT] = '{-1, 8, 0, -8, 1},
  parameter int SHIFT         = 3,
  parameter int OUT_WIDTH     = 9
) (
  input logic clk,
  input logic rst,
  y_derivative_stream_if.slave bus
);
  localparam int H2 = KERNEL_HEIGHT - 1;
  localparam int LW = PIXEL_WIDTH * NUM_FRAMES;
  localparam int SW = PIXEL_WIDTH + 24;
  localparam int CW = FRAME_WIDTH > 1 ? $clog2(FRAME_WIDTH) : 1;
  localparam int RW = FRAME_HEIGHT > 1 ? $clog2(FRAME_HEIGHT) : 1;
  localparam logic signed [SW-1:0] OMAX = (SW'(1) <<< (OUT_WIDTH - 1)) - SW'(1);
  localparam logic signed [SW-1:0] OMIN = ~OMAX;

  logic [LW-1:0] lb [H2][FRAME_WIDTH];
  logic [CW-1:0] col, c;
  logic [RW-1:0] row, r;
  logic v1, b1, v2, b2;
  logic [LW-1:0] win1 [KERNEL_HEIGHT];
  logic signed [SW-1:0] sum [NUM_FRAMES];
  logic signed [SW-1:0] sum2 [NUM_FRAMES];
  logic signed [SW-1:0] sh;
  logic [OUT_WIDTH*NUM_FRAMES-1:0] d_next;
  logic [NUM_FRAMES-1:0] s_next;

  // sof overrides the counters so a restart lands on (0,0) in the same beat
  assign c = bus.in_sof ? '0 : col;
  assign r = bus.in_sof ? '0 : row;

  always_ff @(posedge clk)
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (bus.in_valid) begin
      col <= c == CW'(FRAME_WIDTH - 1) ? '0 : c + 1'b1;
      row <= c != CW'(FRAME_WIDTH - 1) ? r : r == RW'(FRAME_HEIGHT - 1) ? '0 : r + 1'b1;
    end

  // lb[j] holds row r-1-j at each column; a beat shifts its column down one line
  always_ff @(posedge clk)
    if (bus.in_valid && !rst) begin
      lb[0][c] <= bus.pixels_in;
      for (int j = 1; j < H2; j++) lb[j][c] <= lb[j-1][c];
    end

  always_ff @(posedge clk) begin
    v1 <= rst ? 1'b0 : bus.in_valid;
    if (bus.in_valid) begin
      b1 <= r < RW'(H2);
      win1[H2] <= bus.pixels_in;
      for (int k = 0; k < H2; k++) win1[k] <= lb[H2-1-k][c];
    end
  end

  always_comb
    for (int i = 0; i < NUM_FRAMES; i++) begin
      sum[i] = '0;
      for (int k = 0; k < KERNEL_HEIGHT; k++)
        sum[i] = sum[i] + SW'(KERNEL[k]) * $signed(SW'(win1[k][i*PIXEL_WIDTH +: PIXEL_WIDTH]));
    end

  always_ff @(posedge clk) begin
    v2 <= rst ? 1'b0 : v1;
    if (v1) begin
      b2 <= b1;
      sum2 <= sum;
    end
  end

  always_comb begin
    d_next = '0;
    s_next = '0;
    sh = '0;
    for (int i = 0; i < NUM_FRAMES; i++) begin
      sh = sum2[i] >>> SHIFT;
      s_next[i] = sh > OMAX || sh < OMIN;
      d_next[i*OUT_WIDTH +: OUT_WIDTH] = sh > OMAX ? OMAX[OUT_WIDTH-1:0] : sh < OMIN ? OMIN[OUT_WIDTH-1:0] : sh[OUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk)
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.derivs_out <= '0;
      bus.out_border <= 1'b0;
      bus.out_sat <= '0;
    end else begin
      bus.out_valid <= v2;
      if (v2) begin
        bus.out_border <= b2;
        bus.derivs_out <= b2 ? '0 : d_next;
        bus.out_sat <= b2 ? '0 : s_next;
      end
    end
endmodule

// File: tb/tb_y_derivative_stream.sv
// tb_y_derivative_stream: directed self-checking bench for y_derivative_stream
module tb_y_derivative_stream;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_q = 1'b1;
  logic [2:0] dl = '0;
  logic [30:0] last = '0;
  logic [30:0] expq [$];
  logic [30:0] e;
  logic gaps = 1'b0;
  int errors = 0;
  int checks = 0;
  logic [23:0] satrow [6] = '{24'h00FF00, 24'h0000FF, 24'h000000, 24'hFFFF00, 24'h0000FF, 24'h000000};

  always #5 clk = ~clk;

  y_derivative_stream_if #(.PIXEL_WIDTH(8), .NUM_FRAMES(3), .OUT_WIDTH(9)) bus ();

  y_derivative_stream #(.FRAME_WIDTH(40), .FRAME_HEIGHT(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [23:0] p, input logic sof, input logic [26:0] d, input logic b, input logic [2:0] s);
    while (gaps && $urandom_range(1) == 1) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_sof = 1'($urandom);
      bus.pixels_in = 24'($urandom);
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_sof = sof;
    bus.pixels_in = p;
    expq.push_back({d, b, s});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_sof = 1'b0;
    end
  endtask

  always @(posedge clk) begin
    rst_q <= rst;
    dl <= rst ? 3'b000 : {dl[1:0], bus.in_valid};
  end

  always @(negedge clk) begin
    chk("valid_timing", 32'(bus.out_valid), 32'(dl[2]));
    if (bus.out_valid) begin
      chk("queue_nonempty", 32'(expq.size() != 0), 32'd1);
      if (expq.size() != 0) begin
        e = expq.pop_front();
        chk("derivs", 32'(bus.derivs_out), 32'(e[30:4]));
        chk("border", 32'(bus.out_border), 32'(e[3]));
        chk("sat", 32'(bus.out_sat), 32'(e[2:0]));
      end
    end else if (!rst_q)
      chk("hold", 32'({bus.derivs_out, bus.out_border, bus.out_sat}), 32'(last));
    last = {bus.derivs_out, bus.out_border, bus.out_sat};
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_sof = 1'b0;
    bus.pixels_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_derivs", 32'(bus.derivs_out), 32'd0);
    chk("rst_border", 32'(bus.out_border), 32'd0);
    chk("rst_sat", 32'(bus.out_sat), 32'd0);
    rst = 1'b0;
    for (int r = 0; r < 18; r++)
      for (int c = 0; c < 40; c++)
        send({3{8'd100}}, 1'b0, 27'd0, (r % 16) < 4, 3'b000);
    for (int r = 0; r < 11; r++)
      for (int c = 0; c < (r == 10 ? 37 : 40); c++)
        send({3{8'd100}}, r == 0 && c == 0, 27'd0, r < 4, 3'b000);
    gaps = 1'b1;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 40; c++)
        send({8'(5 * (r + 1)), 8'(20 * (r + 1)), 8'(10 * (r + 1))}, r == 0 && c == 0,
             r >= 4 ? {9'h1F8, 9'h1E2, 9'h1F1} : 27'd0, r < 4, 3'b000);
    gaps = 1'b0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < (r == 5 ? 20 : 40); c++)
        send(satrow[r], r == 0 && c == 0,
             r == 4 ? {9'h101, 9'h100, 9'h0FF} : r == 5 ? {9'h000, 9'h000, 9'h100} : 27'd0,
             r < 4, r == 4 ? 3'b011 : r == 5 ? 3'b001 : 3'b000);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expq.delete();
    chk("post_rst_valid0", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("post_rst_valid1", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    chk("post_rst_valid2", 32'(bus.out_valid), 32'd0);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 40; c++)
        send(satrow[r], 1'b0, r == 4 ? {9'h101, 9'h100, 9'h0FF} : 27'd0, r < 4, r == 4 ? 3'b011 : 3'b000);
    idle(6);
    chk("queue_drained", 32'(expq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/y_derivative_stream.md
Y_DERIVATIVE_STREAM -- requirements
Module: y_derivative_stream

Interface
REQ-001 SHALL have parameter PIXEL_WIDTH, default 8: unsigned pixel width per channel.
REQ-002 SHALL have parameter FRAME_WIDTH, default 1024: pixels per line.
REQ-003 SHALL have parameter FRAME_HEIGHT, default 768: lines per frame.
REQ-004 SHALL have parameter NUM_FRAMES, default 3: independent channels, all processed in lockstep.
REQ-005 SHALL have parameter KERNEL_HEIGHT, default 5: vertical tap count; odd, 3..7; H = (KERNEL_HEIGHT-1)/2.
REQ-006 SHALL have parameter KERNEL, default {-1,8,0,-8,1}: signed integer taps; tap 0 applies to the oldest line.
REQ-007 SHALL have parameter SHIFT, default 3: arithmetic right-shift divisor exponent.
REQ-008 SHALL have parameter OUT_WIDTH, default 9: signed output width per channel.
REQ-009 SHALL have port clk, input, 1: single clock; all logic rising-edge.
REQ-010 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-011 SHALL have port in_valid, input, 1: pixel beat present.
REQ-012 SHALL have port in_sof, input, 1: beat is pixel (0,0) of a frame; qualified by in_valid.
REQ-013 SHALL have port pixels_in, input, PIXEL_WIDTH*NUM_FRAMES: channel i at bits [i*PIXEL_WIDTH +: PIXEL_WIDTH].
REQ-014 SHALL have port out_valid, output, 1: derivative beat present.
REQ-015 SHALL have port derivs_out, output, OUT_WIDTH*NUM_FRAMES: channel i at bits [i*OUT_WIDTH +: OUT_WIDTH], two's complement.
REQ-016 SHALL have port out_border, output, 1: window incomplete; derivs_out forced to 0.
REQ-017 SHALL have port out_sat, output, NUM_FRAMES: per-channel saturation occurred on this beat.

Function
REQ-018 SHALL keep per-channel line buffers of KERNEL_HEIGHT-1 lines x FRAME_WIDTH pixels, written only on in_valid beats.
REQ-019 SHALL keep col counter (0..FRAME_WIDTH-1) and row counter (0..FRAME_HEIGHT-1), advanced only on in_valid; col wraps to 0 and increments row; row wraps to 0 after the last line.
REQ-020 SHALL, on in_valid with in_sof, treat the beat as (0,0) regardless of counter state; a mid-frame sof restarts the frame.
REQ-021 SHALL, for an input beat at (r,c), form the column window of rows r-2H..r at col c and compute sum = Σ KERNEL[k]*pixel[r-2H+k] per channel, with no intermediate overflow.
REQ-022 SHALL compute result = floor(sum / 2^SHIFT) via arithmetic shift, then saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; out_sat[i] = 1 when clipping occurred.
REQ-023 SHALL assert out_border and drive all derivs_out to 0 with out_sat = 0 when r < 2H (window spans a previous frame or sof restart).
REQ-024 SHALL produce exactly one out_valid beat per in_valid beat, a fixed 3 clk cycles later, in input order; gaps in in_valid pass through unchanged.
REQ-025 SHALL hold derivs_out, out_border and out_sat stable while out_valid = 0 (last value held).
REQ-026 SHALL have no backpressure; the consumer accepts every out_valid beat.
REQ-027 SHALL never output the last H center rows of a frame; those rows are dropped.

Reset
REQ-028 SHALL, while rst = 1, clear out_valid, derivs_out, out_border, out_sat, col/row counters and all pipeline valid bits to 0; line buffer RAM is not cleared.
REQ-029 SHALL treat the first beat after reset as (0,0) even without in_sof; rst asserted mid-frame discards in-flight beats, and no out_valid is produced for them.

Verification
REQ-030 SHALL pass: constant frame, all pixels 100, defaults -> rows 0..3 out_border = 1 with derivs 0; rows >= 4 derivs 0 with out_border = 0.
REQ-031 SHALL pass: row-ramp lines 10,20,30,40,50 (oldest→newest) -> derivs_out = -15 per channel at the row-4 beats, exactly 3 cycles after each input.
REQ-032 SHALL pass: lines 0,255,0,0,255 -> sum 2295 -> +255 with out_sat = 1; lines 255,0,0,255,0 -> -287 -> -256 with out_sat = 1; lines 0,0,0,255,0 -> -255 with out_sat = 0.
REQ-033 SHALL pass: random in_valid gaps (50% duty) -> out_valid pattern equals in_valid delayed 3 cycles; data matches the reference model.
REQ-034 SHALL pass: in_sof injected at row 10 col 37 -> the next 4 lines report out_border = 1; counters restart at (0,0).
REQ-035 SHALL pass: rst pulsed for 1 cycle mid-line -> out_valid = 0 for the next 3 cycles with no stale beats, and the next beat is treated as (0,0).
